store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write buffer that sits between the single-cycle ARM core's data port and a slower data memory. The memory may take several cycles per write.
- The core issues stores and loads in one cycle with no stall.
- Stores are queued in a circular FIFO and drained to memory over a req/ready handshake.
- Loads read memory combinationally, but data is forwarded from the youngest matching buffered store.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- cpu_we  input  1  store request this cycle (core MemWrite)
- cpu_addr  input  32  byte address (core ALUResult)
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data to core
- full  output  1  all DEPTH entries valid
- empty  output  1  no valid entries
- overflow  output  1  sticky: a store was dropped
- mem_req  output  1  write request to memory
- mem_addr  output  32  write address (head entry)
- mem_wdata  output  32  write data (head entry)
- mem_ready  input  1  memory accepts write this cycle
- mem_raddr  output  32  read address, equals cpu_addr
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset values: count=0, head=tail=0, all valid bits 0, entry storage 0, mem_req=0, mem_addr=0, mem_wdata=0, full=0, empty=1, overflow=0.
- Asserting reset mid-drain discards all entries immediately; mem_req drops asynchronously.
- Storage: DEPTH entries of {valid, addr[31:2], data[31:0]}. Addresses are word-aligned: addr[1:0] is ignored on store and compare, and is 0 on mem_addr.
- Push: cpu_we=1 and (count<DEPTH or pop this cycle). Entry is written at tail; tail=tail+1 mod DEPTH. Pointers wrap at DEPTH.
- Pop: mem_req & mem_ready. Head entry is invalidated; head=head+1 mod DEPTH.
- mem_req = ~empty, registered state only; it does not depend on mem_ready.
- mem_addr/mem_wdata show the head entry and stay stable while mem_req=1 and mem_ready=0.
- Push and pop in the same cycle: count is unchanged. This includes the full case: the store is accepted and overflow is not set.
- Empty case: a push is not visible on mem_req until the next cycle. Minimum store-to-memory latency is 1 cycle.
- Drop: cpu_we=1, count==DEPTH, no pop. The store is discarded and overflow is set, cleared only by reset.
- full = (count==DEPTH); empty = (count==0). Both are registered-state decodes.
- Load path: mem_raddr = cpu_addr.
  - cpu_rdata = data of the youngest valid entry with addr[31:2]==cpu_addr[31:2], else mem_rdata.
  - Youngest means closest behind tail, walking backwards.
  - The entry being pushed in the current cycle is not forwarded; it is visible the next cycle.
  - The entry being popped in the current cycle is still forwarded that cycle.
- Ordering: memory receives stores in issue order; no reordering.

Optional Feature:
- Macro STORE_BUF_COALESCE_EN.
- Defined: a push whose addr[31:2] matches the youngest valid entry overwrites that entry's data in place, with no new allocation and no count change. Coalescing is forbidden if that entry is the head and mem_req=1; in that case it allocates normally. A coalesced store into a full buffer is accepted, not dropped.
- Undefined: every accepted push allocates a new entry.

Test Plan:
- mem_ready=1 constantly; store 0x64←7 → mem_req=1 next cycle with mem_addr=0x64, mem_wdata=7; popped that cycle; empty=1 after.
- mem_ready=0; 4 stores to 0x0,0x4,0x8,0xC → full=1. 5th store 0x10←9 → dropped, overflow=1, count stays 4.
- full, mem_ready=1 for one cycle together with store 0x10←9 → pop 0x0, push accepted, count=4, overflow=0. Drain order is 0x4,0x8,0xC,0x10.
- mem_ready=0; stores 0x13AC←1 then 0x13AC←2560 → load 0x13AC returns 2560 while mem_rdata=0. Load 0x13B0 returns mem_rdata.
- mem_req=1 held and mem_ready=0 for 5 cycles → mem_addr/mem_wdata stable. Assert reset on cycle 3 → mem_req=0 and empty=1 immediately.
- With STORE_BUF_COALESCE_EN: mem_ready=0, stores 0x20←1, 0x40←2, 0x40←3 → count=2. Release mem_ready → memory sees 0x20=1, then 0x40=3.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between a single-cycle core data port and a
// slower data memory. Stores are queued and drained over mem_req/mem_ready.
// Loads read memory combinationally, and a younger buffered store to the same
// word takes precedence over memory.
// Optional build macro STORE_BUF_COALESCE_EN: a store to the same word as the
// youngest entry overwrites that entry in place. The exception is when that
// entry is the head currently being offered to memory.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    // Entry storage; addresses are kept as word addresses (addr[31:2])
    logic              r_valid [DEPTH];
    logic [29:0]       r_addr  [DEPTH];
    logic [31:0]       r_data  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_coal;
    logic              w_alloc;
    logic              w_drop;
    logic [PTR_W-1:0]  w_tail_m1;
    logic [PTR_W:0]    w_count_nxt;
    logic [PTR_W-1:0]  w_idx;
    logic              w_fwd_hit;
    logic [31:0]       w_fwd_data;

    // Status decodes come only from registered state, never from mem_ready
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty   = (r_count == (PTR_W+1)'(0));
    assign w_pop     = ~w_empty & mem_ready;
    assign w_tail_m1 = r_tail - PTR_W'(1);

    assign full      = w_full;
    assign empty     = w_empty;
    assign mem_req   = ~w_empty;
    assign overflow  = r_overflow;
    assign mem_addr  = {r_addr[r_head], 2'b00};
    assign mem_wdata = r_data[r_head];
    assign mem_raddr = cpu_addr;
    assign cpu_rdata = w_fwd_hit ? w_fwd_data : mem_rdata;

`ifdef STORE_BUF_COALESCE_EN
    // Merge into the youngest entry unless it is the head being offered to memory
    always_comb begin
        w_coal = 1'b0;
        if (cpu_we && !w_empty && r_valid[w_tail_m1] &&
            (r_addr[w_tail_m1] == cpu_addr[31:2]) &&
            !((w_tail_m1 == r_head) && !w_empty)) begin
            w_coal = 1'b1;
        end else begin
            w_coal = 1'b0;
        end
    end
`else
    assign w_coal = 1'b0;
`endif

    // Decide whether a store allocates, is dropped, and the resulting occupancy
    always_comb begin
        w_alloc     = cpu_we & ~w_coal & (~w_full | w_pop);
        w_drop      = cpu_we & ~w_coal & w_full & ~w_pop;
        w_count_nxt = r_count;
        case ({w_alloc, w_pop})
            2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Forward from the youngest matching entry: walk oldest-to-youngest so later hits win
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = 32'd0;
        w_idx      = r_tail;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = r_tail - PTR_W'(1) - PTR_W'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == cpu_addr[31:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end else begin
                w_fwd_hit  = w_fwd_hit;
                w_fwd_data = w_fwd_data;
            end
        end
    end

    // Pointer, occupancy and sticky overflow state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_alloc) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage; the allocate write follows the pop so a full push+pop keeps the slot valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= 30'd0;
                r_data[i]  <= 32'd0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= cpu_addr[31:2];
                r_data[r_tail]  <= cpu_wdata;
            end
            if (w_coal) begin
                r_data[w_tail_m1] <= cpu_wdata;
            end
        end
    end

endmodule
